// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared posit field bundle and special encodings for the encoder pipeline
package posit_pkg;

  localparam int POSIT_N  = 32;
  localparam int POSIT_ES = 2;
  localparam int POSIT_RS = $clog2(POSIT_N);

  typedef struct packed {
    logic                        sign;
    logic                        sign_exp;
    logic signed [POSIT_RS+2:0]  regime;
    logic [POSIT_ES-1:0]         exp;
    logic [2*POSIT_N-1:0]        mant;
    logic                        inf;
    logic                        zero;
  } posit_fields_t;

  localparam logic [POSIT_N-1:0] NAR    = {1'b1, {(POSIT_N-1){1'b0}}};
  localparam logic [POSIT_N-1:0] MAXPOS = {1'b0, {(POSIT_N-1){1'b1}}};
  localparam logic [POSIT_N-1:0] MINPOS = {{(POSIT_N-1){1'b0}}, 1'b1};

endpackage

// File: rtl/posit_round_rne.sv
// rtl/posit_round_rne.sv - round-to-nearest-even on the unsigned posit body, clamped to [minpos, maxpos]
module posit_round_rne
  import posit_pkg::*;
#(
  parameter int N = POSIT_N
) (
  input  logic [N-2:0] body,
  input  logic         guard,
  input  logic         sticky,
  output logic [N-2:0] rounded
);

  logic         inc;
  logic [N-1:0] sum;

  assign inc = guard & (sticky | body[0]);
  assign sum = {1'b0, body} + {{(N-1){1'b0}}, inc};

  // A carry out of the body would alias NaR, an all-zero body would alias zero.
  always_comb begin
    rounded = sum[N-2:0];
    if (sum[N-1])
      rounded = {(N-1){1'b1}};
    else if (sum[N-2:0] == '0)
      rounded = {{(N-2){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/posit_encode_round.sv
// rtl/posit_encode_round.sv - 2-stage posit packer with RNE rounding, saturation and valid/ready flow
// POSIT_ENC_FLAGS_EN adds registered inexact_o / saturated_o outputs.
module posit_encode_round
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES,
  parameter int RS = $clog2(N)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 sign_i,
  input  logic                 sign_exp_i,
  input  logic signed [RS+2:0] regime_i,
  input  logic [ES-1:0]        exp_i,
  input  logic [2*N-1:0]       mant_i,
  input  logic                 inf_i,
  input  logic                 zero_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
`ifdef POSIT_ENC_FLAGS_EN
  output logic                 inexact_o,
  output logic                 saturated_o,
`endif
  output logic [N-1:0]         posit_o
);

  localparam int WW = 3*N + ES - 1;
  localparam logic signed [RS+2:0] REG_SAT = (RS+3)'(N-1);

  posit_fields_t f;
  logic          unused_hidden;

  assign f = '{sign: sign_i, sign_exp: sign_exp_i, regime: regime_i, exp: exp_i,
               mant: mant_i, inf: inf_i, zero: zero_i};
  assign unused_hidden = f.mant[2*N-1];

  // stage 1: lay regime run, terminator, exponent and fraction out left-aligned
  logic          run_bit;
  logic          sat_in;
  logic [RS+2:0] shamt;
  logic [WW-1:0] run_mask;
  logic [WW-1:0] wide;

  assign run_bit  = ~f.sign_exp;
  assign sat_in   = (f.regime >= REG_SAT);
  assign shamt    = f.regime;
  assign run_mask = run_bit ? ~({WW{1'b1}} >> shamt) : '0;
  assign wide     = run_mask |
                    ({~run_bit, f.exp, f.mant[2*N-2:0], {(N-1){1'b0}}} >> shamt);

  logic         s1_v, s2_v;
  logic         s1_adv, s2_adv;
  logic         s1_sign, s1_sign_exp, s1_sat, s1_nar, s1_zero;
  logic [N-2:0] s1_body;
  logic         s1_guard, s1_sticky;
  logic [N-1:0] s2_posit;

  assign s2_adv     = ~s2_v | out_ready_i;
  assign s1_adv     = ~s1_v | s2_adv;
  assign in_ready_o = rst_ni & s1_adv;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_v <= 1'b0;
    end else if (s1_adv) begin
      s1_v        <= in_valid_i;
      s1_sign     <= f.sign;
      s1_sign_exp <= f.sign_exp;
      s1_sat      <= sat_in;
      s1_nar      <= f.inf;
      s1_zero     <= f.zero;
      s1_body     <= wide[WW-1 -: N-1];
      s1_guard    <= wide[WW-N];
      s1_sticky   <= |wide[WW-N-1:0];
    end
  end

  // stage 2: round, saturate, negate, specials
  logic [N-2:0] rounded;
  logic [N-2:0] body_fin;
  logic [N-1:0] mag;
  logic [N-1:0] posit_next;

  posit_round_rne #(.N(N)) u_round (
    .body    (s1_body),
    .guard   (s1_guard),
    .sticky  (s1_sticky),
    .rounded (rounded)
  );

  always_comb begin
    body_fin = rounded;
    if (s1_sat)
      body_fin = s1_sign_exp ? {{(N-2){1'b0}}, 1'b1} : {(N-1){1'b1}};
    mag        = {1'b0, body_fin};
    posit_next = s1_sign ? (~mag + 1'b1) : mag;
    if (s1_nar)
      posit_next = NAR;
    else if (s1_zero)
      posit_next = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s2_v     <= 1'b0;
      s2_posit <= '0;
    end else if (s2_adv) begin
      s2_v     <= s1_v;
      s2_posit <= posit_next;
    end
  end

`ifdef POSIT_ENC_FLAGS_EN
  logic normal;
  assign normal = ~s1_nar & ~s1_zero;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      inexact_o   <= 1'b0;
      saturated_o <= 1'b0;
    end else if (s2_adv) begin
      inexact_o   <= normal & (s1_guard | s1_sticky | s1_sat);
      saturated_o <= normal & s1_sat;
    end
  end
`endif

  assign out_valid_o = s2_v;
  assign posit_o     = s2_posit;

endmodule

// File: tb/tb_posit_encode_round.sv
// tb/tb_posit_encode_round.sv - directed self-checking bench for posit_encode_round (N=32, ES=2)
module tb_posit_encode_round;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        in_valid, in_ready;
  logic        sign, sign_exp;
  logic [7:0]  regime;
  logic [1:0]  exp_f;
  logic [63:0] mant;
  logic        inf, zero;
  logic        out_valid, out_ready;
  logic [31:0] posit;
`ifdef POSIT_ENC_FLAGS_EN
  logic        inexact, saturated;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  posit_encode_round dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .sign_i      (sign),
    .sign_exp_i  (sign_exp),
    .regime_i    (regime),
    .exp_i       (exp_f),
    .mant_i      (mant),
    .inf_i       (inf),
    .zero_i      (zero),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
`ifdef POSIT_ENC_FLAGS_EN
    .inexact_o   (inexact),
    .saturated_o (saturated),
`endif
    .posit_o     (posit)
  );

  localparam logic [63:0] ONE = 64'h8000_0000_0000_0000;

  logic        bp_sign [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic        bp_sexp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [1:0]  bp_exp  [4] = '{2'd0, 2'd1, 2'd0, 2'd3};
  logic [31:0] bp_want [4] = '{32'h4000_0000, 32'h4800_0000, 32'hC000_0000, 32'h3800_0000};
  logic [31:0] bp_got  [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_in(input logic s, input logic se, input logic [7:0] r, input logic [1:0] e,
                        input logic [63:0] m, input logic i, input logic z);
    sign = s; sign_exp = se; regime = r; exp_f = e; mant = m; inf = i; zero = z;
  endtask

  // one transaction into an empty pipeline with out_ready high
  task automatic run_vec(input string tag, input logic s, input logic se, input logic [7:0] r,
                         input logic [1:0] e, input logic [63:0] m, input logic i, input logic z,
                         input logic [31:0] want);
    set_in(s, se, r, e, m, i, z);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_lat2"}, {31'd0, out_valid}, 32'd1);
    chk(tag, posit, want);
    @(posedge clk); #1;
  endtask

  int          acc, got, drop_at;
  logic        prev_hold;
  logic [31:0] prev_posit;

  initial begin
    rst_ni = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 1'b0, 8'd0, 2'd0, 64'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_posit", posit, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    run_vec("zero",     1'b0, 1'b0, 8'd1,  2'd0, ONE, 1'b0, 1'b1, 32'h0000_0000);
    run_vec("nar",      1'b0, 1'b0, 8'd1,  2'd0, ONE, 1'b1, 1'b1, 32'h8000_0000);
    run_vec("one",      1'b0, 1'b0, 8'd1,  2'd0, ONE, 1'b0, 1'b0, 32'h4000_0000);
    run_vec("neg_one",  1'b1, 1'b0, 8'd1,  2'd0, ONE, 1'b0, 1'b0, 32'hC000_0000);
    run_vec("exp1",     1'b0, 1'b0, 8'd1,  2'd1, ONE, 1'b0, 1'b0, 32'h4800_0000);
    run_vec("neg_reg",  1'b0, 1'b1, 8'd1,  2'd3, ONE, 1'b0, 1'b0, 32'h3800_0000);
    run_vec("rne_lsb",  1'b0, 1'b0, 8'd1,  2'd0, 64'h8000_0010_0000_0000, 1'b0, 1'b0, 32'h4000_0001);
    run_vec("rne_tie0", 1'b0, 1'b0, 8'd1,  2'd0, 64'h8000_0008_0000_0000, 1'b0, 1'b0, 32'h4000_0000);
    run_vec("rne_tie1", 1'b0, 1'b0, 8'd1,  2'd0, 64'h8000_0018_0000_0000, 1'b0, 1'b0, 32'h4000_0002);
    run_vec("sat_max",  1'b0, 1'b0, 8'd40, 2'd0, ONE, 1'b0, 1'b0, 32'h7FFF_FFFF);
    run_vec("sat_min",  1'b0, 1'b1, 8'd40, 2'd0, ONE, 1'b0, 1'b0, 32'h0000_0001);
    run_vec("sat_nmin", 1'b1, 1'b1, 8'd40, 2'd0, ONE, 1'b0, 1'b0, 32'hFFFF_FFFF);
    run_vec("reg30_tie",1'b0, 1'b0, 8'd30, 2'd2, ONE, 1'b0, 1'b0, 32'h7FFF_FFFE);
    run_vec("reg30_up", 1'b0, 1'b0, 8'd30, 2'd3, ONE, 1'b0, 1'b0, 32'h7FFF_FFFF);

    // backpressure: out_ready low for the first three cycles of a 4-item stream
    acc = 0; got = 0; drop_at = -1; prev_hold = 1'b0; prev_posit = '0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      out_ready = (c >= 3);
      in_valid  = (acc < 4);
      if (acc < 4)
        set_in(bp_sign[acc], bp_sexp[acc], 8'd1, bp_exp[acc], ONE, 1'b0, 1'b0);
      @(negedge clk);
      if (prev_hold) chk("bp_hold", posit, prev_posit);
      if (in_valid && !in_ready && drop_at < 0) drop_at = acc;
      if (out_valid && out_ready) begin
        bp_got[got] = posit;
        got++;
      end
      prev_hold  = out_valid && !out_ready;
      prev_posit = posit;
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_ready_drop", drop_at, 32'd2);
    chk("bp_count", got, 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("bp_item%0d", i), (i < got) ? bp_got[i] : 32'hDEAD_BEEF, bp_want[i]);

    // reset with both stages full
    out_ready = 1'b0;
    set_in(1'b0, 1'b0, 8'd1, 2'd1, ONE, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    set_in(1'b1, 1'b0, 8'd1, 2'd0, ONE, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full_valid", {31'd0, out_valid}, 32'd1);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_posit", posit, 32'd0);
    rst_ni = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_empty", {31'd0, out_valid}, 32'd0);
    run_vec("resume",   1'b0, 1'b0, 8'd1,  2'd1, ONE, 1'b0, 1'b0, 32'h4800_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
